// File: rtl/alu_mul_sequencer.sv
// alu_mul_sequencer
// -----------------
// Multi-cycle 8x8 unsigned shift-add multiplier.
// It does no arithmetic of its own. It borrows the shared ALU for eight
// passes, one per multiplier bit, and returns a 16-bit product.
//
// Ports:
//   i_CLK        clock; all state changes at posedge (ALU evaluates at negedge)
//   i_RST        asynchronous, active-low reset
//   i_Start      start request, sampled at posedge while idle
//   i_A, i_B     multiplicand / multiplier, captured on start
//   i_ALUResult  ALU result (8 bits)
//   i_ALUC       ALU carry out
//   o_ALUReq     high while the sequencer owns the ALU (steers the operand mux)
//   o_ALUOp      opcode driven to the ALU
//   o_ALUData1   ALU operand 1 (accumulator)
//   o_ALUData2   ALU operand 2 (multiplicand)
//   o_Busy       multiply in progress (STEP cycles only)
//   o_Done       one-cycle completion pulse
//   o_Product    16-bit product, held until the next accepted start
//   o_PZ         product == 0, registered together with o_Product
module alu_mul_sequencer (
    input  logic        i_CLK,
    input  logic        i_RST,
    input  logic        i_Start,
    input  logic [7:0]  i_A,
    input  logic [7:0]  i_B,
    input  logic [7:0]  i_ALUResult,
    input  logic        i_ALUC,
    output logic        o_ALUReq,
    output logic [3:0]  o_ALUOp,
    output logic [7:0]  o_ALUData1,
    output logic [7:0]  o_ALUData2,
    output logic        o_Busy,
    output logic        o_Done,
    output logic [15:0] o_Product,
    output logic        o_PZ
);

    // Opcodes taken from the shared ALU opcode table.
    localparam logic [3:0] ALUOP_ADD = 4'h0;
    localparam logic [3:0] ALUOP_PD1 = 4'h8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r;
    state_t      state_s;
    logic [7:0]  hi_r;
    logic [7:0]  lo_r;
    logic [7:0]  mcand_r;
    logic [3:0]  cnt_r;
    logic [15:0] product_r;
    logic        pz_r;
    logic        done_r;
    logic [15:0] shift_s;
    logic        last_step_s;

    assign last_step_s = (state_r == STEP) && (cnt_r == 4'd7);

    // State register.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic. There is no early exit: a multiply always takes eight steps.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (i_Start) begin
                    state_s = STEP;
                end else begin
                    state_s = IDLE;
                end
            end
            STEP: begin
                if (cnt_r == 4'd7) begin
                    state_s = DONE;
                end else begin
                    state_s = STEP;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // ALU-facing outputs. They are decoded from registers only, so they
    // remain stable from the posedge through the ALU's negedge.
    always_comb begin
        o_ALUReq   = 1'b0;
        o_ALUOp    = ALUOP_PD1;
        o_ALUData1 = 8'h00;
        o_ALUData2 = 8'h00;
        o_Busy     = 1'b0;
        case (state_r)
            STEP: begin
                o_ALUReq   = 1'b1;
                o_Busy     = 1'b1;
                o_ALUData1 = hi_r;
                o_ALUData2 = mcand_r;
                if (lo_r[0]) begin
                    o_ALUOp = ALUOP_ADD;
                end else begin
                    o_ALUOp = ALUOP_PD1;
                end
            end
            default: begin
                o_ALUReq   = 1'b0;
                o_ALUOp    = ALUOP_PD1;
                o_ALUData1 = 8'h00;
                o_ALUData2 = 8'h00;
                o_Busy     = 1'b0;
            end
        endcase
    end

    // Right-shift {carry, hi, lo} by one place. When the current multiplier
    // bit is set, the ALU sum replaces hi. Its carry becomes the new MSB; this
    // is what makes 0xFF*0xFF come out right.
    always_comb begin
        shift_s = 16'h0000;
        if (lo_r[0]) begin
            shift_s = {i_ALUC, i_ALUResult, lo_r[7:1]};
        end else begin
            shift_s = {1'b0, hi_r, lo_r[7:1]};
        end
    end

    // Datapath registers. The product is captured on the edge that ends the
    // last step, so it is valid in the same cycle as o_Done.
    always_ff @(posedge i_CLK or negedge i_RST) begin
        if (!i_RST) begin
            hi_r      <= 8'h00;
            lo_r      <= 8'h00;
            mcand_r   <= 8'h00;
            cnt_r     <= 4'd0;
            product_r <= 16'h0000;
            pz_r      <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (i_Start) begin
                        hi_r    <= 8'h00;
                        lo_r    <= i_B;
                        mcand_r <= i_A;
                        cnt_r   <= 4'd0;
                    end
                end
                STEP: begin
                    {hi_r, lo_r} <= shift_s;
                    cnt_r        <= cnt_r + 4'd1;
                    if (last_step_s) begin
                        product_r <= shift_s;
                        pz_r      <= (shift_s == 16'h0000);
                        done_r    <= 1'b1;
                    end
                end
                default: begin
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign o_Product = product_r;
    assign o_PZ      = pz_r;
    assign o_Done    = done_r;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
module tb_alu_mul_sequencer;

    localparam logic [3:0] ALUOP_ADD = 4'h0;
    localparam logic [3:0] ALUOP_PD1 = 4'h8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  a_in = 8'h00;
    logic [7:0]  b_in = 8'h00;
    logic [7:0]  alu_res = 8'h00;
    logic        alu_c = 1'b0;
    logic        alu_req;
    logic [3:0]  alu_op;
    logic [7:0]  alu_d1;
    logic [7:0]  alu_d2;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        pz;

    int n_vec = 0;
    int n_err = 0;

    alu_mul_sequencer dut (
        .i_CLK       (clk),
        .i_RST       (rst_n),
        .i_Start     (start),
        .i_A         (a_in),
        .i_B         (b_in),
        .i_ALUResult (alu_res),
        .i_ALUC      (alu_c),
        .o_ALUReq    (alu_req),
        .o_ALUOp     (alu_op),
        .o_ALUData1  (alu_d1),
        .o_ALUData2  (alu_d2),
        .o_Busy      (busy),
        .o_Done      (done),
        .o_Product   (product),
        .o_PZ        (pz)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU: evaluates at the negedge. ADD gives a 9-bit sum.
    // PD1 passes data1 through and leaves the carry unchanged.
    always @(negedge clk) begin
        if (alu_op == ALUOP_ADD) begin
            {alu_c, alu_res} <= {1'b0, alu_d1} + {1'b0, alu_d2};
        end else begin
            alu_res <= alu_d1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after the start edge. Checks all eight STEP cycles and
    // then the DONE cycle.
    task automatic do_steps(input logic [7:0] a, input logic [7:0] b,
                            input logic [15:0] exp, input bit pulse);
        for (int k = 0; k < 8; k++) begin
            check_val("step_busy", busy, 1);
            check_val("step_req", alu_req, 1);
            check_val("step_op", alu_op, b[k] ? ALUOP_ADD : ALUOP_PD1);
            check_val("step_d2", alu_d2, a);
            check_val("step_done", done, 0);
            if (pulse) start = k[0];
            tick();
        end
        if (pulse) start = 1'b0;
        check_val("done_pulse", done, 1);
        check_val("done_busy", busy, 0);
        check_val("done_req", alu_req, 0);
        check_val("done_op", alu_op, ALUOP_PD1);
        check_val("done_d1", alu_d1, 0);
        check_val("product", product, exp);
        check_val("pz", pz, (exp == 16'h0000) ? 1 : 0);
    endtask

    task automatic run_mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
        a_in  = a;
        b_in  = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        a_in  = ~a;
        b_in  = ~b;
        do_steps(a, b, exp, 1'b0);
        tick();
        check_val("idle_done", done, 0);
        check_val("idle_busy", busy, 0);
        check_val("product_hold", product, exp);
    endtask

    initial begin
        // Reset state.
        #2;
        check_val("rst_product", product, 0);
        check_val("rst_pz", pz, 0);
        check_val("rst_done", done, 0);
        check_val("rst_busy", busy, 0);
        check_val("rst_req", alu_req, 0);
        check_val("rst_op", alu_op, ALUOP_PD1);
        check_val("rst_d1", alu_d1, 0);
        check_val("rst_d2", alu_d2, 0);
        tick();
        rst_n = 1'b1;
        tick();

        // 13 * 11 = 143; ADD happens in steps 0, 1 and 3.
        run_mul(8'h0D, 8'h0B, 16'h008F);
        // Every step adds, so the carry must be shifted in each time.
        run_mul(8'hFF, 8'hFF, 16'hFE01);
        // No bit set: no ADD, zero product, latency still 8.
        run_mul(8'h55, 8'h00, 16'h0000);
        run_mul(8'h01, 8'h80, 16'h0080);

        // Start held high: the second multiply begins in the first IDLE
        // cycle after DONE. Start pulses during its steps are ignored.
        a_in  = 8'h80;
        b_in  = 8'h02;
        start = 1'b1;
        tick();
        a_in  = 8'h03;
        b_in  = 8'h03;
        do_steps(8'h80, 8'h02, 16'h0100, 1'b0);
        tick();
        check_val("held_idle_busy", busy, 0);
        check_val("held_idle_done", done, 0);
        tick();
        start = 1'b0;
        a_in  = 8'hAA;
        b_in  = 8'hAA;
        do_steps(8'h03, 8'h03, 16'h0009, 1'b1);
        tick();
        check_val("held_no_restart", busy, 0);
        tick();
        check_val("held_still_idle", busy, 0);

        // Reset during step 4 aborts at once, with no done pulse.
        a_in  = 8'h33;
        b_in  = 8'h44;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 4; k++) tick();
        check_val("pre_rst_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("abort_busy", busy, 0);
        check_val("abort_req", alu_req, 0);
        check_val("abort_op", alu_op, ALUOP_PD1);
        check_val("abort_d1", alu_d1, 0);
        check_val("abort_d2", alu_d2, 0);
        check_val("abort_product", product, 0);
        check_val("abort_pz", pz, 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("abort_no_done", done, 0);
        end
        rst_n = 1'b1;
        tick();
        run_mul(8'h10, 8'h10, 16'h0100);

        // Random operands against the reference product A*B.
        for (int n = 0; n < 1000; n++) begin
            logic [7:0]  ra;
            logic [7:0]  rb;
            logic [15:0] rp;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rp = 16'(ra) * 16'(rb);
            run_mul(ra, rb, rp);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
